// File: rtl/rv_pkg.sv
// Shared RV32I encodings and the ID/EX payload type used by the decode stage.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic        regwrite;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alusrca;
        logic        alusrcb;
        logic        illegal;
        logic [1:0]  resultsrc;
        logic [3:0]  aluctrl;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    // alt is instr[30]; callers mask it so ADDI can never turn into SUB.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational reads, one write; x0 hardwired to zero.
// DECODE_RF_BYPASS_EN: same-cycle write data is forwarded to the read ports.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_mem [32];
    logic [31:0] w_raw1;
    logic [31:0] w_raw2;

    // Storage: whole array clears on reset, x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign w_raw1 = (i_ra1 == 5'd0) ? 32'h0 : r_mem[i_ra1];
    assign w_raw2 = (i_ra2 == 5'd0) ? 32'h0 : r_mem[i_ra2];

`ifdef DECODE_RF_BYPASS_EN
    assign o_rd1 = (i_we && (i_wa == i_ra1) && (i_ra1 != 5'd0)) ? i_wd : w_raw1;
    assign o_rd2 = (i_we && (i_wa == i_ra2) && (i_ra2 != 5'd0)) ? i_wd : w_raw2;
`else
    assign o_rd1 = w_raw1;
    assign o_rd2 = w_raw2;
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register read and ID/EX register.
// Same-cycle write/read behaviour is selected by DECODE_RF_BYPASS_EN (see regfile).
module decode_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC_E = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] pc4D,
    input  logic        flushE,
    input  logic        regwriteW,
    input  logic [4:0]  rdW,
    input  logic [31:0] resultW,
    output logic [4:0]  rs1D,
    output logic [4:0]  rs2D,
    output logic        regwriteE,
    output logic        memwriteE,
    output logic        branchE,
    output logic        jumpE,
    output logic        jalrE,
    output logic        alusrcaE,
    output logic        alusrcbE,
    output logic        illegalE,
    output logic [1:0]  resultsrcE,
    output logic [3:0]  aluctrlE,
    output logic [2:0]  funct3E,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] immE,
    output logic [31:0] pcE,
    output logic [31:0] pc4E,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    idex_t       w_next;
    idex_t       w_bubble;
    idex_t       r_idex;

    assign rs1D     = instrD[19:15];
    assign rs2D     = instrD[24:20];
    assign w_opcode = instrD[6:0];
    assign w_funct3 = instrD[14:12];

    assign w_imm_i = {{20{instrD[31]}}, instrD[31:20]};
    assign w_imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign w_imm_b = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
    assign w_imm_j = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
    assign w_imm_u = {instrD[31:12], 12'h000};

    regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (rs1D),
        .i_ra2 (rs2D),
        .i_we  (regwriteW),
        .i_wa  (rdW),
        .i_wd  (resultW),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // Bubble value shared by reset and flush.
    always_comb begin
        w_bubble     = '0;
        w_bubble.pc  = RESET_PC_E;
        w_bubble.pc4 = RESET_PC_E;
    end

    // Control decode and immediate selection for the instruction in ID.
    always_comb begin
        w_next         = '0;
        w_next.aluctrl = ALU_ADD;
        w_next.funct3  = w_funct3;
        w_next.rd1     = w_rd1;
        w_next.rd2     = w_rd2;
        w_next.pc      = pcD;
        w_next.pc4     = pc4D;
        w_next.rs1     = rs1D;
        w_next.rs2     = rs2D;
        w_next.rd      = instrD[11:7];
        case (w_opcode)
            OP_R: begin
                w_next.regwrite = 1'b1;
                w_next.aluctrl  = alu_from_funct3(w_funct3, instrD[30]);
            end
            OP_IMM: begin
                w_next.regwrite = 1'b1;
                w_next.alusrcb  = 1'b1;
                w_next.aluctrl  = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && instrD[30]);
                w_next.imm      = w_imm_i;
            end
            OP_LOAD: begin
                w_next.regwrite  = 1'b1;
                w_next.alusrcb   = 1'b1;
                w_next.resultsrc = RES_MEM;
                w_next.imm       = w_imm_i;
            end
            OP_STORE: begin
                w_next.memwrite = 1'b1;
                w_next.alusrcb  = 1'b1;
                w_next.imm      = w_imm_s;
            end
            OP_BRANCH: begin
                w_next.branch  = 1'b1;
                w_next.aluctrl = ALU_SUB;
                w_next.imm     = w_imm_b;
            end
            OP_JAL: begin
                w_next.jump      = 1'b1;
                w_next.regwrite  = 1'b1;
                w_next.resultsrc = RES_PC4;
                w_next.imm       = w_imm_j;
            end
            OP_JALR: begin
                w_next.jump      = 1'b1;
                w_next.jalr      = 1'b1;
                w_next.regwrite  = 1'b1;
                w_next.resultsrc = RES_PC4;
                w_next.imm       = w_imm_i;
            end
            OP_LUI: begin
                w_next.regwrite = 1'b1;
                w_next.alusrcb  = 1'b1;
                w_next.aluctrl  = ALU_PASSB;
                w_next.imm      = w_imm_u;
            end
            OP_AUIPC: begin
                w_next.regwrite = 1'b1;
                w_next.alusrca  = 1'b1;
                w_next.alusrcb  = 1'b1;
                w_next.imm      = w_imm_u;
            end
            default: begin
                // All-zero word is the IF/ID reset value and must not trap.
                w_next.illegal = (instrD != 32'h0);
            end
        endcase
    end

    // ID/EX pipeline register; flush wins over the current decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex <= w_bubble;
        end else if (flushE) begin
            r_idex <= w_bubble;
        end else begin
            r_idex <= w_next;
        end
    end

    assign regwriteE  = r_idex.regwrite;
    assign memwriteE  = r_idex.memwrite;
    assign branchE    = r_idex.branch;
    assign jumpE      = r_idex.jump;
    assign jalrE      = r_idex.jalr;
    assign alusrcaE   = r_idex.alusrca;
    assign alusrcbE   = r_idex.alusrcb;
    assign illegalE   = r_idex.illegal;
    assign resultsrcE = r_idex.resultsrc;
    assign aluctrlE   = r_idex.aluctrl;
    assign funct3E    = r_idex.funct3;
    assign rd1E       = r_idex.rd1;
    assign rd2E       = r_idex.rd2;
    assign immE       = r_idex.imm;
    assign pcE        = r_idex.pc;
    assign pc4E       = r_idex.pc4;
    assign rs1E       = r_idex.rs1;
    assign rs2E       = r_idex.rs2;
    assign rdE        = r_idex.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed test-plan sequence plus random instruction stream.
module tb_decode_stage;
    import rv_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct packed {
        logic [7:0]  en;      // regwrite,memwrite,branch,jump,jalr,alusrca,alusrcb,illegal
        logic [1:0]  rsrc;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instrD = 32'h0, pcD = 32'h0, pc4D = 32'h0, resultW = 32'h0;
    logic        flushE = 1'b0, regwriteW = 1'b0;
    logic [4:0]  rdW = 5'd0;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE;
    logic        regwriteE, memwriteE, branchE, jumpE, jalrE, alusrcaE, alusrcbE, illegalE;
    logic [1:0]  resultsrcE;
    logic [3:0]  aluctrlE;
    logic [2:0]  funct3E;
    logic [31:0] rd1E, rd2E, immE, pcE, pc4E;

    int          n_checks = 0;
    int          n_fail   = 0;
    obs_t        sb[$];
    logic [31:0] regs [32];

    decode_stage #(.RESET_PC_E(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .pc4D(pc4D), .flushE(flushE),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .rs1D(rs1D), .rs2D(rs2D),
        .regwriteE(regwriteE), .memwriteE(memwriteE), .branchE(branchE), .jumpE(jumpE),
        .jalrE(jalrE), .alusrcaE(alusrcaE), .alusrcbE(alusrcbE), .illegalE(illegalE),
        .resultsrcE(resultsrcE), .aluctrlE(aluctrlE), .funct3E(funct3E), .rd1E(rd1E),
        .rd2E(rd2E), .immE(immE), .pcE(pcE), .pc4E(pc4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t a;
        a.en   = {regwriteE, memwriteE, branchE, jumpE, jalrE, alusrcaE, alusrcbE, illegalE};
        a.rsrc = resultsrcE; a.alu = aluctrlE; a.f3 = funct3E;
        a.rd1 = rd1E; a.rd2 = rd2E; a.imm = immE; a.pc = pcE; a.pc4 = pc4E;
        a.rs1 = rs1E; a.rs2 = rs2E; a.rd = rdE;
        return a;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        longint x;
        longint one;
        one = 1;
        x = longint'(v);
        if (x >= (one << (bits - 1))) x = x - (one << bits);
        return 32'(x);
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        logic [3:0] r;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        r = tbl[f3];
        if (alt && f3 == 3'd0) r = 4'd1;
        if (alt && f3 == 3'd5) r = 4'd7;
        return r;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic we,
                                            input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
`ifdef DECODE_RF_BYPASS_EN
        if (we && wr == idx) return wd;
`endif
        return regs[idx];
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic obs_t model(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                                   input logic [31:0] a, input logic [31:0] b);
        obs_t o;
        logic [2:0] f3;
        o = '0;
        if (fl) begin
            o.pc = RPC; o.pc4 = RPC;
            return o;
        end
        f3 = ins[14:12];
        o.f3 = f3; o.rd1 = a; o.rd2 = b; o.pc = pc; o.pc4 = pc + 32'd4;
        o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin o.en = 8'b1000_0000; o.alu = alu_of(f3, ins[30]); end
            7'b0010011: begin o.en = 8'b1000_0010; o.alu = alu_of(f3, (f3 == 3'd5) && ins[30]);
                              o.imm = sext({20'h0, ins[31:20]}, 12); end
            7'b0000011: begin o.en = 8'b1000_0010; o.rsrc = 2'b01; o.imm = sext({20'h0, ins[31:20]}, 12); end
            7'b0100011: begin o.en = 8'b0100_0010; o.imm = sext({20'h0, ins[31:25], ins[11:7]}, 12); end
            7'b1100011: begin o.en = 8'b0010_0000; o.alu = 4'd1;
                              o.imm = sext({19'h0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13); end
            7'b1101111: begin o.en = 8'b1001_0000; o.rsrc = 2'b10;
                              o.imm = sext({11'h0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); end
            7'b1100111: begin o.en = 8'b1001_1000; o.rsrc = 2'b10; o.imm = sext({20'h0, ins[31:20]}, 12); end
            7'b0110111: begin o.en = 8'b1000_0010; o.alu = 4'd10; o.imm = {ins[31:12], 12'h0}; end
            7'b0010111: begin o.en = 8'b1000_0110; o.imm = {ins[31:12], 12'h0}; end
            default:    o.en[0] = (ins != 32'h0);
        endcase
        return o;
    endfunction

    function automatic bit is_valid_op(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    // Drive one cycle of stimulus and queue the expected ID/EX contents.
    task automatic step(input logic [31:0] ins, input logic fl, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] pc);
        logic [31:0] a, b;
        @(negedge clk);
        instrD = ins; pcD = pc; pc4D = pc + 32'd4; flushE = fl;
        regwriteW = we; rdW = wr; resultW = wd;
        #1;
        n_checks++;
        if (rs1D !== ins[19:15] || rs2D !== ins[24:20]) begin
            n_fail++;
            $display("FAIL rs_comb: got rs1D=%0d rs2D=%0d expected %0d %0d", rs1D, rs2D, ins[19:15], ins[24:20]);
        end
        a = rf_read(ins[19:15], we, wr, wd);
        b = rf_read(ins[24:20], we, wr, wd);
        sb.push_back(model(ins, pc, fl, a, b));
        if (we && wr != 5'd0) regs[wr] = wd;
    endtask

    task automatic check_bubble(input string name);
        obs_t e;
        e = '0; e.pc = RPC; e.pc4 = RPC;
        n_checks++;
        if (actual() !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual(), e);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        instrD = 32'h0; regwriteW = 1'b0; flushE = 1'b0;
        rst_n = 1'b0;
        #1;
        check_bubble("mid_reset");
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rst_n = 1'b1;
    endtask

    // Monitor: one ID/EX result per clock edge while the scoreboard holds entries.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (actual() !== e) begin
                    n_fail++;
                    $display("FAIL idex: got %h expected %h", actual(), e);
                end
            end
        end
    end

    initial begin
        logic [31:0] ins, wd;
        logic [6:0]  op;
        logic [4:0]  wr;
        logic        we, fl;
        logic [6:0]  ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;

        #12;
        check_bubble("reset");
        rst_n = 1'b1;

        step(NOP_INSTR, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h100);
        step({7'b0, 5'd0, 5'd5, 3'b000, 5'd6, 7'b0110011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h104);
        step({7'b0, 5'd0, 5'd1, 3'b000, 5'd2, 7'b0110011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h108);
        step({12'hFFF, 5'd7, 3'b000, 5'd8, 7'b0010011}, 1'b0, 1'b1, 5'd7, 32'h1234, 32'h10C);
        step(32'hFE000CE3, 1'b0, 1'b0, 5'd0, 32'h0, 32'h110);
        step({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h114);
        step({1'b0, 10'b0000001000, 1'b0, 8'h00, 5'd1, 7'b1101111}, 1'b1, 1'b0, 5'd0, 32'h0, 32'h118);
        step({1'b0, 10'b0000001000, 1'b0, 8'h00, 5'd1, 7'b1101111}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h118);
        step(NOP_INSTR, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h11C);
        step({7'b0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h120);
        step(32'h0000007F, 1'b0, 1'b0, 5'd0, 32'h0, 32'h124);
        step(NOP_INSTR, 1'b0, 1'b0, 5'd0, 32'h0, 32'h128);
        step(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h12C);
        step({7'b0100000, 5'd3, 5'd5, 3'b101, 5'd9, 7'b0010011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h130);
        step({7'b0100000, 5'd3, 5'd5, 3'b000, 5'd9, 7'b0010011}, 1'b0, 1'b0, 5'd0, 32'h0, 32'h134);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) mid_reset();
            ins = $urandom();
            case ($urandom_range(0, 11))
                9: begin
                    op = 7'($urandom_range(0, 127));
                    while (is_valid_op(op)) op = 7'($urandom_range(0, 127));
                    ins[6:0] = op;
                end
                10: ins = 32'h0;
                11: ins = NOP_INSTR;
                default: ins[6:0] = ops[$urandom_range(0, 8)];
            endcase
            fl = ($urandom_range(0, 7) == 0);
            we = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) wr = ins[19:15];
            wd = $urandom();
            step(ins, fl, we, wr, wd, $urandom() & 32'hFFFF_FFFC);
        end

        @(negedge clk);
        regwriteW = 1'b0; flushE = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It consumes the IF/ID outputs (instrD, pcD, pc4D), decodes control, generates the immediate, and reads the 32x32 register file. The register file is written from the write-back stage. Results are captured into the ID/EX pipeline register for the execute stage, and source register indices go to the hazard unit.

## Interface
Parameters:
- RESET_PC_E, 32'd0, value loaded into pcE/pc4E on reset and flush.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instrD  in  32  instruction from IF/ID
- pcD  in  32  PC of instrD
- pc4D  in  32  pcD+4
- flushE  in  1  insert bubble into ID/EX
- regwriteW  in  1  write-back enable
- rdW  in  5  write-back destination
- resultW  in  32  write-back data
- rs1D, rs2D  out  5  source indices to hazard unit (combinational, instrD[19:15] / [24:20])
- regwriteE, memwriteE, branchE, jumpE, jalrE, alusrcaE, alusrcbE, illegalE  out  1  registered control
- resultsrcE  out  2  00 ALU, 01 load data, 10 pc+4
- aluctrlE  out  4  ALU op
- funct3E  out  3  branch/load/store width
- rd1E, rd2E, immE, pcE, pc4E  out  32  registered operands
- rs1E, rs2E, rdE  out  5  registered indices

## Operation
- Opcode decode:
  - R 0110011: regwrite=1, alusrcb=0.
  - I-ALU 0010011: regwrite=1, alusrcb=1, I-imm.
  - Load 0000011: regwrite=1, resultsrc=01, alusrcb=1, I-imm.
  - Store 0100011: memwrite=1, alusrcb=1, S-imm.
  - Branch 1100011: branch=1, aluctrl=SUB, B-imm.
  - JAL 1101111: jump=1, regwrite=1, resultsrc=10, J-imm.
  - JALR 1100111: jump=1, jalr=1, regwrite=1, resultsrc=10, I-imm.
  - LUI 0110111: regwrite=1, alusrcb=1, aluctrl=PASSB, U-imm.
  - AUIPC 0010111: regwrite=1, alusrca=1 (PC), alusrcb=1, aluctrl=ADD, U-imm.
- aluctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
- R-type uses funct7[5] to select SUB/SRA. I-ALU uses funct7[5] only for shifts (SRAI); ADDI never maps to SUB.
- Load, store, JAL and JALR use ADD.
- Immediates are sign-extended from instr[31]. U-imm is {instr[31:12],12'b0}. B- and J-imm have bit 0 = 0.
- Unrecognised opcode: all enables 0, illegal=1.
- instrD == 32'h0 (the IF/ID reset value) decodes as a bubble with illegal=0.
- Register file:
  - x0 always reads 0.
  - Writes with rdW==0 are ignored.
  - Write on posedge clk when regwriteW.
  - All entries reset to 0.
- ID/EX register:
  - On posedge, loads the decoded values.
  - When flushE=1, it instead loads the bubble: all control 0, illegal 0, data/indices 0, pcE/pc4E = RESET_PC_E.

## Timing
- Latency is 1 cycle: instrD at cycle n appears on the *E outputs after edge n+1.
- rs1D/rs2D are combinational, with zero latency.
- All E outputs reset to the bubble value asynchronously.
- flushE has priority over the decode of the current cycle. There is no stall input on E; the hazard unit stalls by flushing E.
- A write and a read of the same register in the same cycle is resolved per the macro below.
- Reset mid-operation clears the register file and ID/EX immediately; the first post-reset instruction decodes normally.

## Configuration
- DECODE_RF_BYPASS_EN defined: a read of a register being written in the same cycle (regwriteW && rdW==rs && rs!=0) returns resultW (write-first). rd1E/rd2E capture the new value.
- Not defined: the read returns the stored (old) value, and the hazard unit must forward from W.

## Structure
- Shared package rv_pkg holds:
  - opcode localparams;
  - aluctrl encodings;
  - resultsrc encodings;
  - the NOP constant 32'h00000013.
- One sub-module, regfile (2 read ports, 1 write port, bypass under the macro).
- Control decode and immediate generation are combinational in decode_stage.

## Test plan
- Reset: after rst_n release, all E outputs read 0 and illegalE=0. Reading x1 returns 0.
- Write x5=0xDEADBEEF via W, then decode add x6,x5,x0 → rd1E=0xDEADBEEF, aluctrlE=0000, regwriteE=1, rdE=6.
- Same-cycle W write x7=0x1234 and decode of addi x8,x7,-1:
  - with bypass: rd1E=0x1234;
  - without bypass: rd1E=0;
  - in both cases immE=0xFFFFFFFF.
- Decode beq with offset -8 (32'hFE000CE3) → branchE=1, aluctrlE=0001, immE=0xFFFFFFF8. Decode sw → memwriteE=1, regwriteE=0.
- Decode a valid jal while flushE=1 → jumpE=0, regwriteE=0, pcE=RESET_PC_E. On the next cycle, with flushE=0, the same jal → jumpE=1, resultsrcE=10.
- Write to x0 with 0xFFFFFFFF, then read x0 → 0.
- Opcode 1111111 → illegalE=1 with all enables 0. NOP 0x13 → illegalE=0, regwriteE=1, rdE=0.
